y86_mem_wb: RTL and testbench

Parametrised memory-access and write-back unit for the Y86-64 SEQ core. It holds the architectural register file and the word-addressed data memory, and it commits one decoded and executed instruction per start/done handshake. Its memory latency is configurable, and it reports processor status (AOK/HLT/ADR/INS). It sits after `execute` and supplies register read data back to `decode`.

---
 rtl/y86_pkg.sv | 47 ++++
 rtl/y86_regfile.sv | 42 ++++
 rtl/y86_mem_wb.sv | 163 ++++++++++++++++
 tb/tb_y86_mem_wb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants, state enum and icode helpers
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } wbState_t;

  // Instructions that pass through the MEM state
  function automatic logic isMemOp(input logic [3:0] ic);
    return (ic == I_RMMOVQ) || (ic == I_MRMOVQ) || (ic == I_CALL) ||
           (ic == I_RET) || (ic == I_PUSHQ) || (ic == I_POPQ);
  endfunction

  // Instructions that read data memory into valM
  function automatic logic isMemRead(input logic [3:0] ic);
    return (ic == I_MRMOVQ) || (ic == I_RET) || (ic == I_POPQ);
  endfunction

  // Instructions that write data memory
  function automatic logic isMemWrite(input logic [3:0] ic);
    return (ic == I_RMMOVQ) || (ic == I_CALL) || (ic == I_PUSHQ);
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - Y86-64 register file, two write ports (M wins), two read ports
module y86_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int REG_COUNT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              weE,
  input  logic [3:0]        wIdxE,
  input  logic [DATA_W-1:0] wDataE,
  input  logic              weM,
  input  logic [3:0]        wIdxM,
  input  logic [DATA_W-1:0] wDataM,
  input  logic [3:0]        rdIdxA,
  input  logic [3:0]        rdIdxB,
  output logic [DATA_W-1:0] rdDataA,
  output logic [DATA_W-1:0] rdDataB,
  output logic [DATA_W-1:0] rsp
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  // Register update: port M overrides port E on the same index; indices
  // outside the file never match any entry and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (weM && (wIdxM == 4'(i)))      regs[i] <= wDataM;
        else if (weE && (wIdxE == 4'(i))) regs[i] <= wDataE;
      end
    end
  end

  assign rdDataA = (int'(rdIdxA) < REG_COUNT) ? regs[rdIdxA] : '0;
  assign rdDataB = (int'(rdIdxB) < REG_COUNT) ? regs[rdIdxB] : '0;
  assign rsp     = regs[REG_RSP];

endmodule

// File: rtl/y86_mem_wb.sv
// rtl/y86_mem_wb.sv - Y86-64 SEQ memory-access and write-back stage
module y86_mem_wb
  import y86_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int REG_COUNT = 15,
  parameter int MEM_DEPTH = 256,
  parameter int MEM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ready,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valP,
  output logic              done,
  output logic [1:0]        stat,
  output logic [DATA_W-1:0] valM,
  input  logic [3:0]        rd_addr_a,
  input  logic [3:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] rsp
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  wbState_t          stateQ, stateD;
  logic [CNT_W-1:0]  cntQ;
  logic [3:0]        icodeQ, rAQ, rBQ;
  logic              cndQ;
  logic [DATA_W-1:0] valAQ, valEQ, valPQ;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [DATA_W-1:0] memAddr;
  logic [ADDR_W-1:0] memIdx;
  logic              addrBad;
  logic              lastMem;
  logic              accept;

  logic              decWeE, decWeM;
  logic [3:0]        decDstE, decDstM;
  logic [1:0]        statWb;

  assign ready   = (stateQ == ST_IDLE) && (stat == STAT_AOK);
  assign accept  = start && ready;

  // ret/popq address the stack through valA; everything else uses valE
  assign memAddr = ((icodeQ == I_RET) || (icodeQ == I_POPQ)) ? valAQ : valEQ;
  assign memIdx  = memAddr[ADDR_W-1:0];
  assign addrBad = isMemOp(icodeQ) && (memAddr >= DATA_W'(MEM_DEPTH));
  assign lastMem = (stateQ == ST_MEM) && (cntQ == CNT_W'(MEM_LAT - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= ST_IDLE;
    else        stateQ <= stateD;
  end

  // FSM next-state: memory ops linger in MEM for MEM_LAT cycles
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      ST_IDLE: if (accept) stateD = isMemOp(icode) ? ST_MEM : ST_WB;
      ST_MEM:  if (lastMem) stateD = ST_WB;
      ST_WB:   stateD = ST_IDLE;
      default: stateD = ST_IDLE;
    endcase
  end

  // Write-back decode and final status of the latched instruction
  always_comb begin
    decWeE  = 1'b0;
    decDstE = REG_NONE;
    decWeM  = 1'b0;
    decDstM = REG_NONE;
    statWb  = STAT_AOK;
    if (addrBad) begin
      statWb = STAT_ADR;
    end else begin
      case (icodeQ)
        I_HALT:   statWb = STAT_HLT;
        I_CMOVXX: begin decWeE = cndQ; decDstE = rBQ; end
        I_IRMOVQ, I_OPQ: begin decWeE = 1'b1; decDstE = rBQ; end
        I_MRMOVQ: begin decWeM = 1'b1; decDstM = rAQ; end
        I_CALL, I_RET, I_PUSHQ: begin decWeE = 1'b1; decDstE = REG_RSP; end
        I_POPQ: begin
          decWeE  = 1'b1;
          decDstE = REG_RSP;
          decWeM  = 1'b1;
          decDstM = rAQ;
        end
        default: if (icodeQ >= 4'hC) statWb = STAT_INS;
      endcase
    end
  end

  // Operand capture, MEM cycle counter, valM read latch, done pulse, sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntQ   <= '0;
      icodeQ <= I_NOP;
      cndQ   <= 1'b0;
      rAQ    <= REG_NONE;
      rBQ    <= REG_NONE;
      valAQ  <= '0;
      valEQ  <= '0;
      valPQ  <= '0;
      valM   <= '0;
      done   <= 1'b0;
      stat   <= STAT_AOK;
    end else begin
      done <= (stateQ == ST_WB);
      if (accept) begin
        cntQ   <= '0;
        icodeQ <= icode;
        cndQ   <= cnd;
        rAQ    <= rA;
        rBQ    <= rB;
        valAQ  <= valA;
        valEQ  <= valE;
        valPQ  <= valP;
      end else if (stateQ == ST_MEM) begin
        cntQ <= cntQ + CNT_W'(1);
      end
      if (lastMem && isMemRead(icodeQ) && !addrBad) valM <= mem[memIdx];
      if ((stateQ == ST_WB) && (stat == STAT_AOK)) stat <= statWb;
    end
  end

  // Data memory write, confined to the single last MEM edge
  always_ff @(posedge clk) begin
    if (lastMem && isMemWrite(icodeQ) && !addrBad)
      mem[memIdx] <= (icodeQ == I_CALL) ? valPQ : valAQ;
  end

  y86_regfile #(
    .DATA_W   (DATA_W),
    .REG_COUNT(REG_COUNT)
  ) uRegfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .weE    (decWeE && (stateQ == ST_WB)),
    .wIdxE  (decDstE),
    .wDataE (valEQ),
    .weM    (decWeM && (stateQ == ST_WB)),
    .wIdxM  (decDstM),
    .wDataM (valM),
    .rdIdxA (rd_addr_a),
    .rdIdxB (rd_addr_b),
    .rdDataA(rd_data_a),
    .rdDataB(rd_data_b),
    .rsp    (rsp)
  );

endmodule

// File: tb/tb_y86_mem_wb.sv
// tb/tb_y86_mem_wb.sv - scoreboard bench for y86_mem_wb with MEM_LAT=3
module tb_y86_mem_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready;
  logic [3:0]  icode = 4'h1;
  logic        cnd = 1'b0;
  logic [3:0]  rA = 4'hF, rB = 4'hF;
  logic [63:0] valA = '0, valE = '0, valP = '0;
  logic        done;
  logic [1:0]  stat;
  logic [63:0] valM;
  logic [3:0]  rd_addr_a = 4'h0, rd_addr_b = 4'h0;
  logic [63:0] rd_data_a, rd_data_b, rsp;

  typedef struct {
    string       nm;
    logic [1:0]  st;
    logic [63:0] vm;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   nVec = 0;
  int   nErr = 0;
  int   cyc  = 0;

  y86_mem_wb #(.DATA_W(64), .REG_COUNT(15), .MEM_DEPTH(256), .MEM_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .icode(icode), .cnd(cnd), .rA(rA), .rB(rB),
    .valA(valA), .valE(valE), .valP(valP),
    .done(done), .stat(stat), .valM(valM),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rsp(rsp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        nVec++;
        nErr++;
        $display("FAIL unexpected_done at cycle %0d: got done=1 expected 0", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_stat"}, 64'(stat), 64'(e.st));
        chk({e.nm, "_valM"}, valM, e.vm);
        chk({e.nm, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic readReg(input string nm, input logic [3:0] idx, input logic [63:0] exp);
    rd_addr_a = idx;
    rd_addr_b = idx;
    #1;
    chk({nm, "_a"}, rd_data_a, exp);
    chk({nm, "_b"}, rd_data_b, exp);
  endtask

  task automatic drive(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] va,
                       input logic [63:0] ve, input logic [63:0] vp);
    icode = ic; cnd = c; rA = ra; rB = rb; valA = va; valE = ve; valP = vp;
  endtask

  task automatic issue(input string nm, input logic [3:0] ic, input logic c,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] va, input logic [63:0] ve, input logic [63:0] vp,
                       input logic [1:0] expSt, input logic [63:0] expVm, input int expLat);
    exp_t e;
    bit   got;
    @(negedge clk);
    drive(ic, c, ra, rb, va, ve, vp);
    start = 1'b1;
    @(posedge clk);
    #1;
    e.nm = nm; e.st = expSt; e.vm = expVm; e.lat = expLat; e.acc = cyc;
    sb.push_back(e);
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) begin
      nVec++;
      nErr++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", nm);
      sb.delete();
    end
  endtask

  task automatic tryIgnored(input string nm);
    @(negedge clk);
    drive(4'h3, 1'b0, 4'hF, 4'h9, 64'h0, 64'h99, 64'h0);
    start = 1'b1;
    repeat (6) @(negedge clk);
    chk({nm, "_ready_low"}, 64'(ready), 64'h0);
    start = 1'b0;
    readReg({nm, "_r9"}, 4'h9, 64'h0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'h1);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_stat", 64'(stat), 64'h0);
    chk("rst_valM", valM, 64'h0);
    chk("rst_rsp", rsp, 64'h0);
    rst_n = 1'b1;

    issue("irmovq", 4'h3, 0, 4'hF, 4'h2, 0, 64'h1234, 0, 2'b00, 64'h0, 1);
    readReg("irmovq_r2", 4'h2, 64'h1234);
    issue("rmmovq10", 4'h4, 0, 4'hF, 4'hF, 64'hDEAD, 64'h10, 0, 2'b00, 64'h0, 4);
    issue("rmmovq0", 4'h4, 0, 4'hF, 4'hF, 64'h11, 64'h0, 0, 2'b00, 64'h0, 4);
    issue("mrmovq", 4'h5, 0, 4'h5, 4'hF, 0, 64'h10, 0, 2'b00, 64'hDEAD, 4);
    readReg("mrmovq_r5", 4'h5, 64'hDEAD);
    issue("pushq", 4'hA, 0, 4'hF, 4'hF, 64'h7, 64'hF8, 0, 2'b00, 64'hDEAD, 4);
    chk("pushq_rsp", rsp, 64'hF8);
    issue("popq", 4'hB, 0, 4'h4, 4'hF, 64'hF8, 64'h100, 0, 2'b00, 64'h7, 4);
    readReg("popq_r4", 4'h4, 64'h7);
    chk("popq_rsp", rsp, 64'h7);
    issue("cmov_n", 4'h2, 0, 4'hF, 4'h3, 0, 64'h9, 0, 2'b00, 64'h7, 1);
    readReg("cmov_n_r3", 4'h3, 64'h0);
    issue("cmov_y", 4'h2, 1, 4'hF, 4'h3, 0, 64'h9, 0, 2'b00, 64'h7, 1);
    readReg("cmov_y_r3", 4'h3, 64'h9);
    issue("opq_none", 4'h6, 0, 4'hF, 4'hF, 0, 64'h5, 0, 2'b00, 64'h7, 1);
    readReg("opq_r15", 4'hF, 64'h0);
    readReg("opq_r14", 4'hE, 64'h0);
    issue("call", 4'h8, 0, 4'hF, 4'hF, 64'h3, 64'h20, 64'h55, 2'b00, 64'h7, 4);
    chk("call_rsp", rsp, 64'h20);
    issue("ret", 4'h9, 0, 4'hF, 4'hF, 64'h20, 64'h28, 0, 2'b00, 64'h55, 4);
    chk("ret_rsp", rsp, 64'h28);
    issue("mrmov_call", 4'h5, 0, 4'h7, 4'hF, 0, 64'h20, 0, 2'b00, 64'h55, 4);
    readReg("mrmov_call_r7", 4'h7, 64'h55);
    issue("nop", 4'h1, 0, 4'hF, 4'hF, 0, 0, 0, 2'b00, 64'h55, 1);

    issue("mrmov_adr", 4'h5, 0, 4'h8, 4'hF, 0, 64'h1_0000_0010, 0, 2'b10, 64'h55, 4);
    readReg("mrmov_adr_r8", 4'h8, 64'h0);
    tryIgnored("adr1");
    doReset();
    readReg("rst2_r5", 4'h5, 64'h0);

    // Reset in the middle of a MEM phase
    @(negedge clk);
    drive(4'h5, 0, 4'h6, 4'hF, 0, 64'h10, 0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_ready", 64'(ready), 64'h1);
    chk("midrst_done", 64'(done), 64'h0);
    chk("midrst_stat", 64'(stat), 64'h0);
    chk("midrst_valM", valM, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    readReg("midrst_r6", 4'h6, 64'h0);
    issue("post_rst", 4'h3, 0, 4'hF, 4'h6, 0, 64'h77, 0, 2'b00, 64'h0, 1);
    readReg("post_rst_r6", 4'h6, 64'h77);
    issue("m0_before", 4'h5, 0, 4'h1, 4'hF, 0, 64'h0, 0, 2'b00, 64'h11, 4);

    issue("rmmov_adr", 4'h4, 0, 4'hF, 4'hF, 64'hBAD, 64'h100, 0, 2'b10, 64'h11, 4);
    tryIgnored("adr2");
    doReset();
    issue("m0_after", 4'h5, 0, 4'h1, 4'hF, 0, 64'h0, 0, 2'b00, 64'h11, 4);
    readReg("m0_after_r1", 4'h1, 64'h11);

    issue("ins", 4'hC, 0, 4'h1, 4'h1, 0, 64'h5, 0, 2'b11, 64'h11, 1);
    readReg("ins_r1", 4'h1, 64'h11);
    tryIgnored("ins");
    doReset();
    issue("halt", 4'h0, 0, 4'hF, 4'hF, 0, 0, 0, 2'b01, 64'h0, 1);
    @(negedge clk);
    chk("halt_ready", 64'(ready), 64'h0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      nVec++;
      nErr++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
